fixed_mac_ci: RTL

Multi-cycle Nios II custom-instruction stage that consumes the signed fixed-point product of the 32x32 multiplier and turns it into a usable result. It rounds and rescales the product, saturates it, and optionally accumulates it into an internal guarded accumulator.
It sits between the CPU custom-instruction slave interface and the fixed multiplier. It gives software a single-instruction fixed-point MUL/MAC with start/done handshaking.

---
 rtl/fixed_mac_ci_pkg.sv | 24 ++
 rtl/fixed_mac_ci_sat.sv | 27 ++
 rtl/fixed_mac_ci.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fixed_mac_ci_pkg.sv
// Shared constants, opcodes and FSM state encoding for the fixed-point MUL/MAC
// custom-instruction stage.
package fixed_pkg;

    localparam int WIDTH     = 32;
    localparam int FRAC_BITS = 16;
    localparam int ACC_GUARD = 8;

    localparam logic [1:0] OP_MUL  = 2'd0;
    localparam logic [1:0] OP_MAC  = 2'd1;
    localparam logic [1:0] OP_CLR  = 2'd2;
    localparam logic [1:0] OP_READ = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_SCALE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Half an LSB of the result format, added before the shift to round half up.
    localparam longint ROUND_HALF = longint'(1) << (FRAC_BITS - 1);

endpackage

// File: rtl/fixed_mac_ci_sat.sv
// Signed saturator: narrows IN_W bits to OUT_W bits, clamping to the most
// positive / most negative OUT_W value when the input does not fit.
// Intended for IN_W > OUT_W.
module fixed_sat #(
    parameter int IN_W  = 40,
    parameter int OUT_W = 32
) (
    input  logic signed [IN_W-1:0]  in_i,
    output logic signed [OUT_W-1:0] out_o
);

    localparam int HEAD_W = IN_W - OUT_W + 1;

    // The value fits when every bit from the top down to the OUT_W sign bit agrees.
    logic [HEAD_W-1:0] head;
    assign head = in_i[IN_W-1:OUT_W-1];

    // Pass through when representable, otherwise clamp toward the input's sign.
    always_comb begin
        out_o = in_i[OUT_W-1:0];
        if (!((&head) || !(|head))) begin
            out_o = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fixed_mac_ci.sv
// Fixed-point MUL/MAC custom-instruction stage: multiply, round, rescale,
// saturate and optionally accumulate into a guarded accumulator.
//
// Handshake: start is a one-cycle request, sampled only in IDLE while clk_en is
// high; it is ignored in every other state. done is a registered pulse that is
// high for exactly one enabled cycle and result is valid while done is high,
// holding its value until the next completion. clk_en low freezes everything,
// including a pending done pulse.
module fixed_mac_ci
    import fixed_pkg::*;
#(
    parameter int WIDTH     = fixed_pkg::WIDTH,
    parameter int FRAC_BITS = fixed_pkg::FRAC_BITS,
    parameter int ACC_GUARD = fixed_pkg::ACC_GUARD
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             start,
    input  logic [1:0]       n,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int ACC_W  = WIDTH + ACC_GUARD;
    localparam int PROD_W = 2 * WIDTH;
    localparam int SUM_W  = PROD_W + 1;
    localparam logic signed [SUM_W-1:0] ROUND_K = SUM_W'(1) <<< (FRAC_BITS - 1);

    state_e                    state_q, state_d;
    logic [1:0]                op_q;
    logic signed [WIDTH-1:0]   a_q, b_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]          result_q;
    logic                      done_q;

    logic                      load_ops;
    logic                      commit;
    logic [1:0]                eff_op;

    logic signed [SUM_W-1:0]   rounded_sum;
    logic signed [SUM_W-1:0]   shifted;
    logic signed [ACC_W-1:0]   scaled;
    logic signed [ACC_W:0]     mac_sum;
    logic signed [ACC_W-1:0]   mac_sat;
    logic signed [ACC_W-1:0]   res_src;
    logic signed [WIDTH-1:0]   result_d;

    // Next-state logic; CLR/READ commit straight from IDLE using the live opcode,
    // MUL/MAC commit from SCALE using the latched one.
    always_comb begin
        state_d  = state_q;
        load_ops = 1'b0;
        commit   = 1'b0;
        eff_op   = op_q;
        case (state_q)
            ST_IDLE: begin
                eff_op = n;
                if (start) begin
                    if (n[1]) begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d  = ST_MUL;
                        load_ops = 1'b1;
                    end
                end
            end
            ST_MUL:   state_d = ST_SCALE;
            ST_SCALE: begin
                state_d = ST_DONE;
                commit  = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Round half up, then arithmetic shift back into the result format.
    assign rounded_sum = $signed({prod_q[PROD_W-1], prod_q}) + ROUND_K;
    assign shifted     = rounded_sum >>> FRAC_BITS;

    fixed_sat #(.IN_W(SUM_W), .OUT_W(ACC_W)) u_sat_scaled (
        .in_i  (shifted),
        .out_o (scaled)
    );

    assign mac_sum = $signed({acc_q[ACC_W-1], acc_q}) + $signed({scaled[ACC_W-1], scaled});

    fixed_sat #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_sat_acc (
        .in_i  (mac_sum),
        .out_o (mac_sat)
    );

    // Accumulator update and result source selection for the committing op.
    always_comb begin
        acc_d = acc_q;
        case (eff_op)
            OP_MAC:  acc_d = mac_sat;
            OP_CLR:  acc_d = '0;
            default: acc_d = acc_q;
        endcase
        res_src = (eff_op == OP_MUL) ? scaled : acc_d;
    end

    fixed_sat #(.IN_W(ACC_W), .OUT_W(WIDTH)) u_sat_res (
        .in_i  (res_src),
        .out_o (result_d)
    );

    // State, operand, product, accumulator and result registers; all frozen by clk_en.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'd0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            done_q  <= (state_d == ST_DONE);
            if (load_ops) begin
                a_q  <= dataa;
                b_q  <= datab;
                op_q <= n;
            end
            if (state_q == ST_MUL) begin
                prod_q <= PROD_W'(a_q) * PROD_W'(b_q);
            end
            if (commit) begin
                acc_q    <= acc_d;
                result_q <= result_d;
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule
